// File: rtl/sr_latch_ctrl.sv
// rtl/sr_latch_ctrl.sv - round-robin sequencer for a gated SR latch bank; optional readback check: SR_LATCH_CTRL_VERIFY_EN
module sr_latch_ctrl #(
    parameter int NREQ  = 4,
    parameter int IDXW  = 3,
    parameter int PULSE = 2
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        op,
    input  logic [NREQ*IDXW-1:0]   idx,
    input  logic [(1<<IDXW)-1:0]   Q_fb,
    output logic [NREQ-1:0]        ack,
    output logic [(1<<IDXW)-1:0]   S,
    output logic [(1<<IDXW)-1:0]   R,
    output logic [(1<<IDXW)-1:0]   en,
    output logic                   busy,
    output logic                   err
);

    localparam int NFLAG = 1 << IDXW;
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_ACK
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic              cop_q, cop_d;
    logic [IDXW-1:0]   cidx_q, cidx_d;
    logic [NFLAG-1:0]  s_q, s_d;
    logic [NFLAG-1:0]  r_q, r_d;
    logic [NFLAG-1:0]  en_q, en_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [PW-1:0]     pick;
    logic [NFLAG-1:0]  sel_d;

    // Requester number base+off, wrapped modulo NREQ (works for non-power-of-two NREQ)
    function automatic logic [PW-1:0] rr_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return PW'(s);
    endfunction

    // Round-robin search: first pending requester at or after rr_q
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[rr_add(rr_q, i)]) begin
                found = 1'b1;
                pick  = rr_add(rr_q, i);
            end
        end
    end

    // Next-state logic; outputs are derived from the next state so they leave flops
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        cop_d   = cop_q;
        cidx_d  = cidx_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    gnt_d   = pick;
                    cop_d   = op[pick];
                    cidx_d  = idx[int'(pick)*IDXW +: IDXW];
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = 4'd0;
                state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_q == 4'(PULSE - 1)) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HOLD: begin
                state_d = ST_ACK;
            end
            ST_ACK: begin
                rr_d    = rr_add(gnt_q, 1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // S/R span SETUP..HOLD so they bracket the en pulse on both sides
        sel_d  = NFLAG'(1) << cidx_d;
        s_d    = '0;
        r_d    = '0;
        en_d   = '0;
        ack_d  = '0;
        busy_d = (state_d != ST_IDLE);
        if (state_d == ST_SETUP || state_d == ST_PULSE || state_d == ST_HOLD) begin
            s_d = cop_d ? sel_d : '0;
            r_d = cop_d ? '0 : sel_d;
        end
        if (state_d == ST_PULSE) begin
            en_d = sel_d;
        end
        if (state_d == ST_ACK) begin
            ack_d = NREQ'(1) << gnt_d;
        end
    end

    // State, command capture and registered outputs; reset clears the bank drive at once
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            rr_q    <= '0;
            cop_q   <= 1'b0;
            cidx_q  <= '0;
            s_q     <= '0;
            r_q     <= '0;
            en_q    <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cop_q   <= cop_d;
            cidx_q  <= cidx_d;
            s_q     <= s_d;
            r_q     <= r_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign S    = s_q;
    assign R    = r_q;
    assign en   = en_q;
    assign ack  = ack_q;
    assign busy = busy_q;

`ifdef SR_LATCH_CTRL_VERIFY_EN
    logic err_q, err_d;

    // Readback in HOLD: latch must already show the commanded value; flag is sticky
    always_comb begin
        err_d = err_q;
        if (state_q == ST_HOLD && (Q_fb[cidx_q] != cop_q)) begin
            err_d = 1'b1;
        end
    end

    // Sticky error register, cleared only by reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_q_fb;
    assign unused_q_fb = ^Q_fb;
    assign err         = 1'b0;
`endif

endmodule
